// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request and encoded-word handshake bundle for imm_encoder
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic        out_err;
  modport master (
    output in_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instruction, out_err
  );
  modport slave (
    input  in_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instruction, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs fields and a signed immediate into an I/S/B/U/J instruction word
module imm_encoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  imm_encoder_if.slave     bus,
  output logic [ERR_W-1:0] err_count
);
  logic             r_s1_valid;
  logic [2:0]       r_fmt;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [31:0]      r_imm;
  logic             r_s1_err;
  logic             r_s2_valid;
  logic [31:0]      r_instr;
  logic             r_s2_err;
  logic [ERR_W-1:0] r_err_count;
  logic             w_s1_adv;
  logic             w_accept;
  logic             w_err;
  logic             w_sx12;
  logic             w_sx13;
  logic             w_sx21;
  logic [31:0]      w_packed;
  assign w_s1_adv        = r_s1_valid && (!r_s2_valid || bus.out_ready);
  assign bus.in_ready    = !r_s1_valid || w_s1_adv;
  assign w_accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid   = r_s2_valid;
  assign bus.instruction = r_instr;
  assign bus.out_err     = r_s2_err;
  assign err_count       = r_err_count;
  // range/alignment check on the incoming immediate, captured with the request
  always_comb begin
    w_sx12 = &bus.imm[31:11] || ~|bus.imm[31:11];
    w_sx13 = &bus.imm[31:12] || ~|bus.imm[31:12];
    w_sx21 = &bus.imm[31:20] || ~|bus.imm[31:20];
    w_err  = bus.fmt == 3'd0 || bus.fmt == 3'd1 ? !w_sx12 :
             bus.fmt == 3'd2 ? !(w_sx13 && !bus.imm[0]) :
             bus.fmt == 3'd3 ? |bus.imm[11:0] :
             bus.fmt == 3'd4 ? !(w_sx21 && !bus.imm[0]) : 1'b1;
  end
  // field packing of the held request; out-of-range immediates are simply truncated
  always_comb
    w_packed = r_fmt == 3'd0 ? {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode} :
               r_fmt == 3'd1 ? {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode} :
               r_fmt == 3'd2 ? {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3, r_imm[4:1], r_imm[11], r_opcode} :
               r_fmt == 3'd3 ? {r_imm[31:12], r_rd, r_opcode} :
               r_fmt == 3'd4 ? {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode} : 32'h0;
  // stage 1: capture request and its error flag, empty when handed to stage 2 without refill
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_fmt      <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_s1_err   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_fmt      <= bus.fmt;
      r_opcode   <= bus.opcode;
      r_funct3   <= bus.funct3;
      r_rd       <= bus.rd;
      r_rs1      <= bus.rs1;
      r_rs2      <= bus.rs2;
      r_imm      <= bus.imm;
      r_s1_err   <= w_err;
    end else if (w_s1_adv)
      r_s1_valid <= 1'b0;
  // stage 2: output register; word keeps its last value when the stage empties
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_instr    <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_instr    <= w_packed;
      r_s2_err   <= r_s1_err;
    end else if (bus.out_ready)
      r_s2_valid <= 1'b0;
  // saturating count of errored words actually delivered
  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_err_count <= '0;
    else if (r_s2_valid && bus.out_ready && r_s2_err && !(&r_err_count))
      r_err_count <= r_err_count + 1'b1;
endmodule
